md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Sequencer for the multiply/divide resource in the pipelined MIPS core.
- Accepts an issue from the E stage and runs a fixed-latency multi-cycle operation, then commits HI/LO.
- Drives the Busy indication and a D-stage stall request to the hazard controller.
- Honours exception flush at issue.

Parameters:
MULT_CYCLES, 5, Busy cycles for MULT/MULTU (must be >= 1)
DIV_CYCLES, 10, Busy cycles for DIV/DIVU (must be >= 1)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  E-stage issue strobe for an md-class instruction
Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
A  input  32  forwarded RS operand (E stage)
B  input  32  forwarded RT operand (E stage)
Flush  input  1  exception/EXL flush of the E-stage instruction this cycle
MdUseD  input  1  D-stage instruction is MULT/DIV/MFHI/MFLO/MTHI/MTLO class
HI  output  32  HI register
LO  output  32  LO register
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse after HI/LO commit
StallMD  output  1  stall request for F/D (PauseF/PauseD source)

Behaviour:
- Reset low (async): state IDLE, counter 0, HI=0, LO=0, Busy=0, Done=0, shadow registers 0. Reset low mid-operation aborts the operation with no commit.
- States: IDLE, RUN.
- Issue acceptance: Start=1 & Flush=0 & state IDLE. If Flush=1, the Start is discarded and nothing changes.
- MULT/MULTU accepted at edge T:
  - Signed or unsigned 64-bit product of A and B is latched into shadow {SH,SL}.
  - Counter loads MULT_CYCLES-1 and state goes to RUN.
  - Busy is high for exactly MULT_CYCLES cycles after edge T.
- DIV/DIVU accepted at edge T:
  - LO_shadow = quotient, HI_shadow = remainder. Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Counter loads DIV_CYCLES-1 and state goes to RUN.
  - B==0: the operation still runs the full DIV_CYCLES with Busy asserted, but HI/LO are not modified at commit.
- RUN:
  - Counter decrements each cycle.
  - At the edge where counter==0: HI/LO <= shadow, state goes to IDLE, Busy falls, and Done=1 for the following cycle only.
- MTHI/MTLO accepted:
  - HI (resp. LO) <= A at the same edge.
  - No RUN state, Busy stays 0, Done=0.
- Op 6/7 accepted: no effect.
- Start while RUN is a protocol violation (StallMD prevents it). It is ignored, and the in-flight operation and HI/LO are unaffected.
- Flush while RUN does not cancel the in-flight operation. It completes and commits.
- Start in the same cycle Done=1 is legal (state is IDLE) and is accepted normally.
- Busy is registered. StallMD = MdUseD & (Busy | (Start & ~Flush & Op<=3)), combinational.
- HI/LO read by MFHI/MFLO are the committed registers only; shadow values are never visible.

Test Plan:
- MULT with A=0xFFFFFFFF, B=2 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; Done pulses 1 cycle.
- MULTU with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
- DIV with A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with A=7, B=0 -> Busy 10 cycles; HI/LO keep their prior values.
- MTLO with A=0x12345678, then MDUseD=1 with no Busy -> LO=0x12345678 next cycle; Busy=0 and StallMD=0 throughout.
- Start=1 MULT with Flush=1 -> Busy stays 0, HI/LO unchanged. A MULT issued, then Flush asserted during RUN -> still commits after 5 cycles.
- MULT running, MdUseD=1 -> StallMD=1 every Busy cycle. Reset driven low at Busy cycle 3 -> Busy=0, HI=LO=0 immediately with no Done; a new MULT after reset release runs a full 5 cycles.

Source files
------------

// File: rtl/md_sched.sv
// Multiply/divide sequencer: latches a product or quotient/remainder into shadow
// registers at issue, holds Busy for a fixed latency, then commits HI/LO.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  input  logic        MdUseD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Done,
  output logic        StallMD
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        sh_q, sh_d, sl_q, sl_d;
  logic [31:0]        hi_d, lo_d;
  logic               wr_q, wr_d;
  logic               busy_d, done_d;
  logic               issue;

  logic [63:0]        a_sx, b_sx, prod_s, prod_u;
  logic [31:0]        dvsr;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;

  // Datapath: both signed and unsigned results are formed; Op selects at issue
  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divide-by-zero result is discarded at commit; substitute 1 to keep the divider defined
  assign dvsr  = (B == 32'd0) ? 32'd1 : B;
  assign quo_s = $signed(A) / $signed(dvsr);
  assign rem_s = $signed(A) % $signed(dvsr);
  assign quo_u = A / dvsr;
  assign rem_u = A % dvsr;

  assign issue   = Start & ~Flush & (state_q == IDLE);
  assign StallMD = MdUseD & (Busy | (Start & ~Flush & (Op <= OP_DIVU)));

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    sl_d    = sl_q;
    wr_d    = wr_q;
    hi_d    = HI;
    lo_d    = LO;
    busy_d  = Busy;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (issue) begin
          case (Op)
            OP_MULT, OP_MULTU: begin
              {sh_d, sl_d} = (Op == OP_MULT) ? prod_s : prod_u;
              wr_d         = 1'b1;
              cnt_d        = CNT_W'(MULT_CYCLES - 1);
              state_d      = RUN;
              busy_d       = 1'b1;
            end
            OP_DIV: begin
              sh_d    = rem_s;
              sl_d    = quo_s;
              wr_d    = (B != 32'd0);
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              state_d = RUN;
              busy_d  = 1'b1;
            end
            OP_DIVU: begin
              sh_d    = rem_u;
              sl_d    = quo_u;
              wr_d    = (B != 32'd0);
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              state_d = RUN;
              busy_d  = 1'b1;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(0)) begin
          if (wr_q) begin
            hi_d = sh_q;
            lo_d = sl_q;
          end
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      sl_q    <= '0;
      wr_q    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      sl_q    <= sl_d;
      wr_q    <= wr_d;
      HI      <= hi_d;
      LO      <= lo_d;
      Busy    <= busy_d;
      Done    <= done_d;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO queued at issue, compared on Done.
module tb_md_sched;

  logic        Clk = 1'b0;
  logic        Reset, Start, Flush, MdUseD;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        Busy, Done, StallMD;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];
  logic [63:0] mon_e;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .MdUseD(MdUseD), .HI(HI), .LO(LO), .Busy(Busy),
    .Done(Done), .StallMD(StallMD)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Independent reference for the arithmetic, in 64-bit integer terms
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    longint sa, sbv, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = prev;
    case (op)
      3'd0: res = sa * sbv;
      3'd1: res = ua * ub;
      3'd2: if (b != 32'd0) begin
        q = sa / sbv;
        r = sa % sbv;
        res = {r[31:0], q[31:0]};
      end
      3'd3: if (b != 32'd0) begin
        uq = ua / ub;
        ur = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
      default: res = prev;
    endcase
    return res;
  endfunction

  // Scoreboard consumer: every Done must match the oldest queued expectation
  always @(negedge Clk) begin
    if (Reset === 1'b1 && Done === 1'b1) begin
      chk("done_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("commit_hilo", {HI, LO}, mon_e);
      end
    end
  end

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit mid_flush, input bit mid_start);
    logic [63:0] e, prev;
    int n, cyc;
    prev = {exp_hi, exp_lo};
    e    = model(op, a, b, prev);
    cyc  = (op < 3'd2) ? 5 : 10;
    Start = 1'b1; Op = op; A = a; B = b; Flush = 1'b0; MdUseD = 1'b1;
    #1 chk("stall_issue", 64'(StallMD), 64'd1);
    sb_q.push_back(e);
    {exp_hi, exp_lo} = e;
    @(negedge Clk);
    Start = 1'b0;
    n = 0;
    for (int i = 0; i < 64 && Busy === 1'b1; i++) begin
      n++;
      chk("stall_busy", 64'(StallMD), 64'd1);
      if (n == 1) chk("hilo_hidden", {HI, LO}, prev);
      Flush = (mid_flush && n == 2);
      if (mid_start && n == 3) begin
        Start = 1'b1; Op = 3'd2; A = 32'h0000_0063; B = 32'h0000_0002;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
    end
    Flush = 1'b0; Start = 1'b0;
    chk("busy_cycles", 64'(n), 64'(cyc));
    chk("done_pulse", 64'(Done), 64'd1);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1; Op = op; A = a; B = 32'd0; Flush = 1'b0; MdUseD = 1'b1;
    #1 chk("mt_stall_issue", 64'(StallMD), 64'd0);
    @(negedge Clk);
    Start = 1'b0;
    if (op == 3'd4) exp_hi = a; else exp_lo = a;
    chk("mt_hilo", {HI, LO}, {exp_hi, exp_lo});
    chk("mt_busy", 64'(Busy), 64'd0);
    chk("mt_done", 64'(Done), 64'd0);
    chk("mt_stall", 64'(StallMD), 64'd0);
  endtask

  task automatic flushed(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b; Flush = 1'b1; MdUseD = 1'b1;
    #1 chk("flush_stall", 64'(StallMD), 64'd0);
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    chk("flush_busy", 64'(Busy), 64'd0);
    @(negedge Clk);
    chk("flush_hilo", {HI, LO}, {exp_hi, exp_lo});
    chk("flush_busy2", 64'(Busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b0; Start = 1'b0; Flush = 1'b0; MdUseD = 1'b0;
    Op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge Clk);
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    Reset = 1'b1;
    @(negedge Clk);

    run_md(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    run_md(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_neg_result", {exp_hi, exp_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(3'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    @(negedge Clk);
    chk("done_one_cycle", 64'(Done), 64'd0);
    chk("div0_keep", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

    mt(3'd5, 32'h1234_5678);
    chk("mtlo_value", 64'(LO), 64'h1234_5678);
    mt(3'd4, 32'hCAFE_F00D);

    flushed(3'd0, 32'd9, 32'd9);
    flushed(3'd2, 32'd9, 32'd3);

    run_md(3'd0, 32'd3, 32'hFFFF_FFFB, 1'b1, 1'b0);
    run_md(3'd2, 32'd100, 32'd7, 1'b0, 1'b1);
    chk("viol_ignored", {HI, LO}, 64'h0000_0002_0000_000E);

    for (int k = 0; k < 8; k++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_md(rop, ra, rb, 1'b0, 1'b0);
    end

    // Reset in the middle of a MULT: abort with no commit
    Start = 1'b1; Op = 3'd0; A = 32'd6; B = 32'd7; MdUseD = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    chk("pre_reset_busy", 64'(Busy), 64'd1);
    Reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_hilo", {HI, LO}, 64'd0);
    chk("midrst_done", 64'(Done), 64'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    chk("no_stale_done", 64'(Done), 64'd0);
    run_md(3'd0, 32'd6, 32'd7, 1'b0, 1'b0);
    @(negedge Clk);
    chk("final_hilo", {HI, LO}, 64'd42);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
